// File: rtl/whack_a_mole_ctrl.sv
// Whack-a-mole game controller: paces moles with GAP/SHOW timers, judges button
// presses against the shown hole, and keeps score and lives for the VGA renderer.
module whack_a_mole_ctrl #(
  parameter int         SHOW_TICKS = 25000000,
  parameter int         GAP_TICKS  = 5000000,
  parameter int         LIVES_INIT = 3,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [1:0] mole_index,
  output logic       mole_on,
  output logic [7:0] score,
  output logic [1:0] lives,
  output logic       game_over,
  output logic       hit_pulse,
  output logic       miss_pulse
);

  localparam int MAX_TICKS = (SHOW_TICKS > GAP_TICKS) ? SHOW_TICKS : GAP_TICKS;
  localparam int TIMER_W   = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_TICKS - 1);
  localparam logic [TIMER_W-1:0] SHOW_LOAD  = TIMER_W'(SHOW_TICKS - 1);
  localparam logic [1:0]         LIVES_LOAD = 2'(LIVES_INIT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] GAP  = 2'd1;
  localparam logic [1:0] SHOW = 2'd2;
  localparam logic [1:0] OVER = 2'd3;

  logic [1:0]         state;
  logic [TIMER_W-1:0] timer;
  logic [3:0]         btn_q;
  logic [7:0]         lfsr;
  logic [3:0]         press;
  logic [1:0]         next_mole;
  logic               lfsr_fb;

  // The next mole steps past the previous hole so a hole never repeats back to back.
  always_comb begin
    press     = btn & ~btn_q;
    lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    next_mole = lfsr[1:0];
    if (lfsr[1:0] == mole_index) begin
      next_mole = lfsr[1:0] + 2'd1;
    end
  end

  assign mole_on   = (state == SHOW);
  assign game_over = (state == OVER);

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state      <= IDLE;
      timer      <= '0;
      btn_q      <= '0;
      lfsr       <= LFSR_SEED;
      mole_index <= '0;
      score      <= '0;
      lives      <= '0;
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
    end else begin
      btn_q      <= btn;
      lfsr       <= {lfsr[6:0], lfsr_fb};
      hit_pulse  <= 1'b0;
      miss_pulse <= 1'b0;
      case (state)
        IDLE, OVER: begin
          if (start) begin
            score <= '0;
            lives <= LIVES_LOAD;
            timer <= GAP_LOAD;
            state <= GAP;
          end
        end
        GAP: begin
          if (timer == '0) begin
            mole_index <= next_mole;
            timer      <= SHOW_LOAD;
            state      <= SHOW;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        SHOW: begin
          // A correct press wins over wrong bits and over the last-cycle timeout.
          if (press[mole_index]) begin
            hit_pulse <= 1'b1;
            if (score != 8'hFF) begin
              score <= score + 8'd1;
            end
            timer <= GAP_LOAD;
            state <= GAP;
          end else if ((press != 4'd0) || (timer == '0)) begin
            miss_pulse <= 1'b1;
            lives      <= lives - 2'd1;
            if (lives == 2'd1) begin
              state <= OVER;
            end else begin
              timer <= GAP_LOAD;
              state <= GAP;
            end
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_whack_a_mole_ctrl.sv
// Bench for whack_a_mole_ctrl: a phase/elapsed-cycle game model checked every cycle,
// plus directed scenarios with literal timing, score and lives expectations.
module tb_whack_a_mole_ctrl;

  localparam int         SHOW = 10;
  localparam int         GAP  = 4;
  localparam int         LI   = 3;
  localparam logic [7:0] SEED = 8'hA5;

  logic       CLOCK_50;
  logic       resetn;
  logic       start;
  logic [3:0] btn;
  logic [1:0] mole_index;
  logic       mole_on;
  logic [7:0] score;
  logic [1:0] lives;
  logic       game_over;
  logic       hit_pulse;
  logic       miss_pulse;

  int total = 0;
  int bad   = 0;
  bit check_en = 0;

  whack_a_mole_ctrl #(
    .SHOW_TICKS(SHOW), .GAP_TICKS(GAP), .LIVES_INIT(LI), .LFSR_SEED(SEED)
  ) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .btn(btn),
    .mole_index(mole_index), .mole_on(mole_on), .score(score), .lives(lives),
    .game_over(game_over), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  // Game model: tracks the phase and how many cycles have been spent in it.
  typedef enum {P_IDLE, P_GAP, P_SHOW, P_OVER} phase_t;
  phase_t     m_phase;
  int         m_elapsed;
  logic [7:0] m_lfsr;
  logic [3:0] m_prev_btn;
  logic [1:0] m_mole;
  int         m_score;
  int         m_lives;
  bit         m_hit;
  bit         m_miss;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic model_step();
    logic [3:0] pr;
    logic [1:0] pick;
    bit hit;
    bit miss;
    if (!resetn) begin
      m_phase = P_IDLE; m_elapsed = 0; m_lfsr = SEED; m_prev_btn = 4'd0;
      m_mole = 2'd0; m_score = 0; m_lives = 0; m_hit = 0; m_miss = 0;
      return;
    end
    pr = btn & ~m_prev_btn;
    m_prev_btn = btn;
    hit = 0;
    miss = 0;
    case (m_phase)
      P_IDLE, P_OVER: begin
        if (start) begin
          m_score = 0; m_lives = LI; m_phase = P_GAP; m_elapsed = 0;
        end
      end
      P_GAP: begin
        m_elapsed++;
        if (m_elapsed == GAP) begin
          pick = m_lfsr[1:0];
          if (pick == m_mole) pick = pick + 2'd1;
          m_mole = pick;
          m_phase = P_SHOW;
          m_elapsed = 0;
        end
      end
      P_SHOW: begin
        m_elapsed++;
        if (pr[m_mole]) hit = 1;
        else if (pr != 4'd0 || m_elapsed == SHOW) miss = 1;
        if (hit) m_score = (m_score < 255) ? m_score + 1 : 255;
        if (miss) m_lives--;
        if (hit || miss) begin
          m_elapsed = 0;
          m_phase = (m_lives == 0) ? P_OVER : P_GAP;
        end
      end
      default: m_phase = P_IDLE;
    endcase
    m_hit = hit;
    m_miss = miss;
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  always @(posedge CLOCK_50) model_step();

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Every cycle after the first reset edge, all outputs must match the model.
  always @(negedge CLOCK_50) begin
    if (check_en) begin
      checkOutput("mole_index", int'(mole_index), int'(m_mole));
      checkOutput("mole_on", int'(mole_on), int'(m_phase == P_SHOW));
      checkOutput("game_over", int'(game_over), int'(m_phase == P_OVER));
      checkOutput("score", int'(score), m_score);
      checkOutput("lives", int'(lives), m_lives);
      checkOutput("hit_pulse", int'(hit_pulse), int'(m_hit));
      checkOutput("miss_pulse", int'(miss_pulse), int'(m_miss));
    end
  end

  task automatic applyStimulus(input logic rn, input logic st, input logic [3:0] b);
    @(posedge CLOCK_50);
    #1;
    resetn = rn;
    start  = st;
    btn    = b;
  endtask

  // Returns at the negedge of the first SHOW cycle.
  task automatic wait_show(output int gap_n);
    bit seen = 0;
    gap_n = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge CLOCK_50);
      if (mole_on) seen = 1;
      else gap_n++;
    end
    if (!seen) checkOutput("wait_show_timeout", 0, 1);
  endtask

  int gap_n;
  int show_n;
  bit done;
  logic [1:0] prev_mole;
  bit has_prev;
  logic [3:0] seen_mask;
  logic [3:0] onehot;

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    btn    = 4'd0;
    @(posedge CLOCK_50);
    #1 check_en = 1;
    @(negedge CLOCK_50);
    checkOutput("rst_mole_on", int'(mole_on), 0);
    checkOutput("rst_score", int'(score), 0);
    checkOutput("rst_lives", int'(lives), 0);
    checkOutput("rst_game_over", int'(game_over), 0);
    applyStimulus(1, 0, 4'd0);
    applyStimulus(1, 0, 4'd0);

    $display("[TB] timeout game");
    applyStimulus(1, 1, 4'd0);
    applyStimulus(1, 0, 4'd0);
    gap_n = 0;
    for (int k = 1; k <= 3; k++) begin
      show_n = 0;
      done = 0;
      for (int c = 0; c < 200 && !done; c++) begin
        @(negedge CLOCK_50);
        if (mole_on) show_n++;
        else if (show_n == 0) gap_n++;
        else done = 1;
      end
      if (!done) checkOutput("timeout_wait", 0, 1);
      checkOutput("gap_len", gap_n, 4);
      checkOutput("show_len", show_n, 10);
      checkOutput("timeout_miss_pulse", int'(miss_pulse), 1);
      checkOutput("timeout_lives", int'(lives), 3 - k);
      gap_n = 1;
    end
    checkOutput("over_game_over", int'(game_over), 1);
    checkOutput("over_lives", int'(lives), 0);
    checkOutput("over_score", int'(score), 0);

    $display("[TB] restart and hit on third show cycle");
    applyStimulus(1, 1, 4'd0);
    applyStimulus(1, 0, 4'd0);
    @(negedge CLOCK_50);
    checkOutput("restart_score", int'(score), 0);
    checkOutput("restart_lives", int'(lives), 3);
    checkOutput("restart_game_over", int'(game_over), 0);
    applyStimulus(1, 1, 4'd0);
    applyStimulus(1, 0, 4'd0);
    wait_show(gap_n);
    onehot = 4'b0001 << m_mole;
    applyStimulus(1, 0, 4'd0);
    applyStimulus(1, 0, onehot);
    applyStimulus(1, 0, 4'd0);
    @(negedge CLOCK_50);
    checkOutput("hit3_pulse", int'(hit_pulse), 1);
    checkOutput("hit3_score", int'(score), 1);
    checkOutput("hit3_mole_on", int'(mole_on), 0);

    $display("[TB] wrong plus correct, then wrong only");
    wait_show(gap_n);
    onehot = (4'b0001 << m_mole) | (4'b0001 << (m_mole + 2'd1));
    applyStimulus(1, 0, onehot);
    applyStimulus(1, 0, 4'd0);
    @(negedge CLOCK_50);
    checkOutput("both_hit_pulse", int'(hit_pulse), 1);
    checkOutput("both_score", int'(score), 2);
    checkOutput("both_lives", int'(lives), 3);
    wait_show(gap_n);
    onehot = 4'b0001 << (m_mole + 2'd2);
    applyStimulus(1, 0, onehot);
    applyStimulus(1, 0, 4'd0);
    @(negedge CLOCK_50);
    checkOutput("wrong_miss_pulse", int'(miss_pulse), 1);
    checkOutput("wrong_lives", int'(lives), 2);
    checkOutput("wrong_score", int'(score), 2);

    $display("[TB] held buttons across gap into show");
    applyStimulus(1, 0, 4'hF);
    wait_show(gap_n);
    done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge CLOCK_50);
      if (!mole_on) done = 1;
    end
    if (!done) checkOutput("held_wait", 0, 1);
    checkOutput("held_miss_pulse", int'(miss_pulse), 1);
    checkOutput("held_hit_pulse", int'(hit_pulse), 0);
    checkOutput("held_lives", int'(lives), 1);
    checkOutput("held_score", int'(score), 2);
    applyStimulus(1, 0, 4'd0);

    $display("[TB] press on last show cycle");
    wait_show(gap_n);
    onehot = 4'b0001 << m_mole;
    repeat (8) applyStimulus(1, 0, 4'd0);
    applyStimulus(1, 0, onehot);
    applyStimulus(1, 0, 4'd0);
    @(negedge CLOCK_50);
    checkOutput("last_hit_pulse", int'(hit_pulse), 1);
    checkOutput("last_miss_pulse", int'(miss_pulse), 0);
    checkOutput("last_score", int'(score), 3);
    checkOutput("last_lives", int'(lives), 1);

    $display("[TB] long run to saturation");
    has_prev = 0;
    seen_mask = 4'd0;
    for (int k = 0; k < 260; k++) begin
      wait_show(gap_n);
      if (has_prev) checkOutput("mole_repeat", int'(mole_index == prev_mole), 0);
      prev_mole = mole_index;
      has_prev = 1;
      seen_mask = seen_mask | (4'b0001 << mole_index);
      onehot = 4'b0001 << m_mole;
      applyStimulus(1, 0, onehot);
      applyStimulus(1, 0, 4'd0);
      @(negedge CLOCK_50);
    end
    checkOutput("holes_seen", int'(seen_mask), 15);
    checkOutput("sat_score", int'(score), 255);
    checkOutput("sat_hit_pulse", int'(hit_pulse), 1);
    checkOutput("sat_lives", int'(lives), 1);

    $display("[TB] reset during show");
    wait_show(gap_n);
    applyStimulus(0, 0, 4'd0);
    applyStimulus(1, 0, 4'd0);
    @(negedge CLOCK_50);
    checkOutput("rst2_mole_on", int'(mole_on), 0);
    checkOutput("rst2_mole_index", int'(mole_index), 0);
    checkOutput("rst2_score", int'(score), 0);
    checkOutput("rst2_lives", int'(lives), 0);
    checkOutput("rst2_game_over", int'(game_over), 0);
    checkOutput("rst2_pulses", int'({hit_pulse, miss_pulse}), 0);
    applyStimulus(1, 0, 4'd0);
    @(negedge CLOCK_50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/whack_a_mole_ctrl.md
WHACK_A_MOLE_CTRL -- requirements
Module: whack_a_mole_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL update on the rising edge of CLOCK_50.
REQ-002 Parameter SHOW_TICKS, default 25000000, SHALL set the cycles a mole is shown.
REQ-003 Parameter GAP_TICKS, default 5000000, SHALL set the blank cycles between moles.
REQ-004 Parameter LIVES_INIT, default 3, range 1..3, SHALL set the lives at game start.
REQ-005 Parameter LFSR_SEED, default 8'hA5, nonzero, SHALL set the LFSR reset value.
REQ-006 CLOCK_50  in  1  50 MHz system clock.
REQ-007 resetn  in  1  synchronous active-low reset.
REQ-008 start  in  1  level, already synchronized; starts or restarts a game.
REQ-009 btn  in  4  active-high whack buttons, already synchronized and debounced; bit i targets hole i.
REQ-010 mole_index  out  2  hole of the current or last mole; feeds the VGA renderer.
REQ-011 mole_on  out  1  high while a mole is shown.
REQ-012 score  out  8  hit count, saturating.
REQ-013 lives  out  2  remaining lives.
REQ-014 game_over  out  1  high in OVER state.
REQ-015 hit_pulse, miss_pulse  out  1 each  one-cycle event strobes.

Function
REQ-016 Edge detect: press = btn & ~btn_q, where btn_q is btn registered one cycle; only press events SHALL be acted on.
REQ-017 An 8-bit Fibonacci LFSR (taps 8,6,5,4) SHALL advance every cycle outside reset and SHALL never reach zero.
REQ-018 FSM states SHALL be IDLE, GAP, SHOW and OVER; mole_on = (state==SHOW) and game_over = (state==OVER).
REQ-019 IDLE/OVER with start=1 SHALL load score=0, lives=LIVES_INIT and timer=GAP_TICKS-1, then go to GAP; start in GAP or SHOW SHALL be ignored.
REQ-020 GAP SHALL decrement the timer each cycle; at timer==0 it SHALL latch the new mole_index, load timer=SHOW_TICKS-1 and go to SHOW, giving exactly GAP_TICKS GAP cycles.
REQ-021 New mole = lfsr[1:0]; if that equals the previous mole_index, new mole = previous+1 mod 4, so consecutive moles never repeat.
REQ-022 SHOW with press[mole_index]=1 SHALL count as a hit: score+1, saturating at 255; hit takes priority when other bits are pressed in the same cycle.
REQ-023 SHOW with press nonzero but press[mole_index]=0 SHALL count as a miss: lives-1.
REQ-024 SHOW with timer==0 and no press SHALL count as a miss; a press in the timer==0 cycle SHALL be judged per REQ-022 and REQ-023 instead.
REQ-025 Without a press, SHOW SHALL last exactly SHOW_TICKS cycles.
REQ-026 After a hit or miss: if the resulting lives==0, go to OVER; otherwise load timer=GAP_TICKS-1 and go to GAP.
REQ-027 hit_pulse and miss_pulse SHALL be registered, high for exactly one cycle, and coincident with the first cycle showing the updated score, lives and state.
REQ-028 Presses in IDLE, GAP and OVER SHALL be ignored, with no score, lives or pulse change.
REQ-029 mole_index SHALL hold its value outside SHOW; score and lives SHALL hold in OVER until the next start.

Reset
REQ-030 With resetn=0 at a clock edge, state SHALL become IDLE and mole_index, score, lives, timer, btn_q, hit_pulse and miss_pulse SHALL become 0.
REQ-031 With resetn=0 at a clock edge, the LFSR SHALL load LFSR_SEED, and game_over and mole_on SHALL be 0.
REQ-032 Reset asserted mid-game, in any state, SHALL take priority over every other event in that cycle.

Verification (SHOW_TICKS=10, GAP_TICKS=4, LIVES_INIT=3)
REQ-033 Start pulse, no presses -> 4 GAP cycles, then mole_on high for 10 cycles, then miss_pulse and lives=2; after 3 misses, game_over=1, lives=0, score=0.
REQ-034 Press btn bit mole_index on SHOW cycle 3 -> next cycle hit_pulse=1, score=1, mole_on=0, state GAP.
REQ-035 Press the wrong bit and the correct bit in the same cycle -> hit, score+1, lives unchanged; pressing only the wrong bit -> miss, lives-1.
REQ-036 Hold a button across a GAP->SHOW boundary -> no hit (no rising edge); presses during GAP -> no change; press on the timer==0 SHOW cycle -> judged as a hit or miss, not a timeout.
REQ-037 Over 200 consecutive moles, no two consecutive mole_index values SHALL be equal and all 4 holes SHALL appear; score SHALL saturate at 255 when a hit occurs at 255.
REQ-038 resetn=0 during SHOW -> next cycle all outputs 0 and state IDLE; start in OVER -> score=0, lives=3, new game.
